// File: rtl/network_cfg_pkg.sv
// rtl/network_cfg_pkg.sv - shared widths, frame layout and D2 helper for the config chain loader
package network_cfg_pkg;

    localparam int HW_WIDTH  = 5;
    localparam int T_WIDTH   = 5;
    localparam int D1_WIDTH  = 5;
    localparam int D2_WIDTH  = 9;
    localparam int NNEUR     = 16;
    localparam int VTH_WIDTH = 5;
    localparam int TPD_WIDTH = 4;
    localparam int NLAYER    = 5;

    localparam int FRAME_W = HW_WIDTH + T_WIDTH + D1_WIDTH + D2_WIDTH
                           + NNEUR * (VTH_WIDTH + 1) + TPD_WIDTH + 4;
    localparam int CNT_W   = $clog2(FRAME_W);

    localparam int OFS_HW        = 0;
    localparam int OFS_T         = OFS_HW + HW_WIDTH;
    localparam int OFS_D1        = OFS_T + T_WIDTH;
    localparam int OFS_D2        = OFS_D1 + D1_WIDTH;
    localparam int OFS_VTH       = OFS_D2 + D2_WIDTH;
    localparam int OFS_NOFF      = OFS_VTH + NNEUR * VTH_WIDTH;
    localparam int OFS_TPD       = OFS_NOFF + NNEUR;
    localparam int OFS_PD_EN_MEM = OFS_TPD + TPD_WIDTH;
    localparam int OFS_PD_EN_CIM = OFS_PD_EN_MEM + 1;
    localparam int OFS_BP        = OFS_PD_EN_CIM + 1;
    localparam int OFS_SWP       = OFS_BP + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    // Small feature maps (HW < 3) fall back to D2 = T instead of a negative product
    function automatic logic [D2_WIDTH-1:0] auto_d2(input logic [HW_WIDTH-1:0] hw,
                                                   input logic [T_WIDTH-1:0]  t);
        logic [15:0] full;
        if (hw < HW_WIDTH'(3)) begin
            full = 16'(t);
        end else begin
            full = (16'(hw) - 16'd3) * (16'(t) + 16'd1) + 16'(t);
        end
        return full[D2_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/network_cfg_loader_if.sv
// rtl/network_cfg_loader_if.sv - record load handshake between host and config loader
interface network_cfg_loader_if
    import network_cfg_pkg::*;
    ();

    logic                         LOAD_VALID;
    logic                         LOAD_READY;
    logic                         AUTO_DELAY;
    logic [HW_WIDTH-1:0]          LD_HW;
    logic [T_WIDTH-1:0]           LD_T;
    logic [D1_WIDTH-1:0]          LD_D1;
    logic [D2_WIDTH-1:0]          LD_D2;
    logic [NNEUR*VTH_WIDTH-1:0]   LD_VTH;
    logic [NNEUR-1:0]             LD_NOFF;
    logic [TPD_WIDTH-1:0]         LD_TPD;
    logic                         LD_PD_EN_MEM;
    logic                         LD_PD_EN_CIM;
    logic                         LD_BP;
    logic                         LD_SWP;

    modport master (
        output LOAD_VALID, AUTO_DELAY, LD_HW, LD_T, LD_D1, LD_D2, LD_VTH, LD_NOFF,
               LD_TPD, LD_PD_EN_MEM, LD_PD_EN_CIM, LD_BP, LD_SWP,
        input  LOAD_READY
    );

    modport slave (
        input  LOAD_VALID, AUTO_DELAY, LD_HW, LD_T, LD_D1, LD_D2, LD_VTH, LD_NOFF,
               LD_TPD, LD_PD_EN_MEM, LD_PD_EN_CIM, LD_BP, LD_SWP,
        output LOAD_READY
    );

endinterface

// File: rtl/network_cfg_pack.sv
// rtl/network_cfg_pack.sv - combinational packing of one layer record into a chain frame
module network_cfg_pack
    import network_cfg_pkg::*;
(
    input  logic                       auto_delay,
    input  logic [HW_WIDTH-1:0]        hw,
    input  logic [T_WIDTH-1:0]         t,
    input  logic [D1_WIDTH-1:0]        d1_in,
    input  logic [D2_WIDTH-1:0]        d2_in,
    input  logic [NNEUR*VTH_WIDTH-1:0] vth,
    input  logic [NNEUR-1:0]           noff,
    input  logic [TPD_WIDTH-1:0]       tpd,
    input  logic                       pd_en_mem,
    input  logic                       pd_en_cim,
    input  logic                       bp,
    input  logic                       swp,
    output logic [FRAME_W-1:0]         frame
);

    logic [D1_WIDTH-1:0] d1;
    logic [D2_WIDTH-1:0] d2;

    always_comb begin
        d1 = auto_delay ? D1_WIDTH'(t) : d1_in;
        d2 = auto_delay ? auto_d2(hw, t) : d2_in;
    end

    always_comb begin
        frame                             = '0;
        frame[OFS_HW   +: HW_WIDTH]       = hw;
        frame[OFS_T    +: T_WIDTH]        = t;
        frame[OFS_D1   +: D1_WIDTH]       = d1;
        frame[OFS_D2   +: D2_WIDTH]       = d2;
        frame[OFS_VTH  +: NNEUR*VTH_WIDTH] = vth;
        frame[OFS_NOFF +: NNEUR]          = noff;
        frame[OFS_TPD  +: TPD_WIDTH]      = tpd;
        frame[OFS_PD_EN_MEM]              = pd_en_mem;
        frame[OFS_PD_EN_CIM]              = pd_en_cim;
        frame[OFS_BP]                     = bp;
        frame[OFS_SWP]                    = swp;
    end

endmodule

// File: rtl/network_cfg_loader.sv
// rtl/network_cfg_loader.sv - accepts layer records and shifts them LSB-first into the config chain
module network_cfg_loader
    import network_cfg_pkg::*;
(
    input  logic                 CLK,
    input  logic                 RST,
    network_cfg_loader_if.slave  ld,
    output logic                 CFG_WE,
    output logic                 CFG_D,
    output logic                 BUSY,
    output logic                 CFG_DONE,
    output logic [2:0]           LAYER_CNT
);

    state_t               state;
    logic [FRAME_W-1:0]   frame;
    logic [FRAME_W-1:0]   sr;
    logic [CNT_W-1:0]     bit_cnt;

    network_cfg_pack u_pack (
        .auto_delay (ld.AUTO_DELAY),
        .hw         (ld.LD_HW),
        .t          (ld.LD_T),
        .d1_in      (ld.LD_D1),
        .d2_in      (ld.LD_D2),
        .vth        (ld.LD_VTH),
        .noff       (ld.LD_NOFF),
        .tpd        (ld.LD_TPD),
        .pd_en_mem  (ld.LD_PD_EN_MEM),
        .pd_en_cim  (ld.LD_PD_EN_CIM),
        .bp         (ld.LD_BP),
        .swp        (ld.LD_SWP),
        .frame      (frame)
    );

    // Bit 0 is driven on the acceptance edge, so sr holds only the bits still to go
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state         <= ST_IDLE;
            sr            <= '0;
            bit_cnt       <= '0;
            ld.LOAD_READY <= 1'b1;
            CFG_WE        <= 1'b0;
            CFG_D         <= 1'b0;
            BUSY          <= 1'b0;
            CFG_DONE      <= 1'b0;
            LAYER_CNT     <= 3'd0;
        end else begin
            CFG_DONE <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (ld.LOAD_VALID) begin
                        sr            <= frame >> 1;
                        CFG_D         <= frame[0];
                        CFG_WE        <= 1'b1;
                        bit_cnt       <= '0;
                        ld.LOAD_READY <= 1'b0;
                        BUSY          <= 1'b1;
                        state         <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (bit_cnt == CNT_W'(FRAME_W - 1)) begin
                        CFG_WE <= 1'b0;
                        CFG_D  <= 1'b0;
                        state  <= ST_GAP;
                        if (LAYER_CNT == 3'(NLAYER - 1)) begin
                            LAYER_CNT <= 3'd0;
                            CFG_DONE  <= 1'b1;
                        end else begin
                            LAYER_CNT <= LAYER_CNT + 3'd1;
                        end
                    end else begin
                        CFG_D   <= sr[0];
                        sr      <= sr >> 1;
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                ST_GAP: begin
                    BUSY          <= 1'b0;
                    ld.LOAD_READY <= 1'b1;
                    state         <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_network_cfg_loader.sv
// tb/tb_network_cfg_loader.sv - randomized self-checking bench for network_cfg_loader
module tb_network_cfg_loader;
    import network_cfg_pkg::*;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       CFG_WE, CFG_D, BUSY, CFG_DONE;
    logic [2:0] LAYER_CNT;

    network_cfg_loader_if ld ();

    network_cfg_loader dut (
        .CLK       (CLK),
        .RST       (RST),
        .ld        (ld.slave),
        .CFG_WE    (CFG_WE),
        .CFG_D     (CFG_D),
        .BUSY      (BUSY),
        .CFG_DONE  (CFG_DONE),
        .LAYER_CNT (LAYER_CNT)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference frame built directly from the documented bit positions
    function automatic logic [127:0] model_frame(input bit auto_d, input int hw, input int t,
                                                 input int d1, input int d2,
                                                 input logic [79:0] vth, input logic [15:0] noff,
                                                 input int tpd, input logic [3:0] modes);
        int d1e;
        int d2e;
        d1e = auto_d ? t : d1;
        if (!auto_d)     d2e = d2;
        else if (hw < 3) d2e = t;
        else             d2e = ((hw - 3) * (t + 1) + t) % 512;
        return 128'(hw) | (128'(t) << 5) | (128'(d1e) << 10) | (128'(d2e) << 15)
             | (128'(vth) << 24) | (128'(noff) << 104) | (128'(tpd) << 120)
             | (128'(modes) << 124);
    endfunction

    function automatic logic [127:0] frame_from_if();
        return model_frame(ld.AUTO_DELAY, int'(ld.LD_HW), int'(ld.LD_T), int'(ld.LD_D1),
                           int'(ld.LD_D2), ld.LD_VTH, ld.LD_NOFF, int'(ld.LD_TPD),
                           {ld.LD_SWP, ld.LD_BP, ld.LD_PD_EN_CIM, ld.LD_PD_EN_MEM});
    endfunction

    // Model: position within the current frame (-1 idle, 0..127 bit index, 128 gap)
    int           m_pos = -1;
    logic [127:0] m_frame = '0;
    int           m_layer = 0;
    bit           m_done = 1'b0;
    int           acc_cnt = 0;
    int           acc_cyc = 0;
    int           prev_acc_cyc = 0;
    int           cyc = 0;

    initial forever begin
        @(posedge CLK or posedge RST);
        if (RST) begin
            m_pos   = -1;
            m_layer = 0;
            m_done  = 1'b0;
        end else begin
            cyc++;
            m_done = 1'b0;
            if (m_pos < 0) begin
                if (ld.LOAD_VALID === 1'b1) begin
                    m_pos        = 0;
                    m_frame      = frame_from_if();
                    acc_cnt++;
                    prev_acc_cyc = acc_cyc;
                    acc_cyc      = cyc;
                end
            end else if (m_pos < 127) begin
                m_pos++;
            end else if (m_pos == 127) begin
                m_pos = 128;
                m_layer++;
                if (m_layer == NLAYER) begin
                    m_layer = 0;
                    m_done  = 1'b1;
                end
            end else begin
                m_pos = -1;
            end
        end
    end

    bit we_e;
    bit d_e;
    initial forever begin
        @(negedge CLK);
        if (!RST) begin
            we_e = (m_pos >= 0) && (m_pos < 128);
            d_e  = we_e ? m_frame[m_pos] : 1'b0;
            chk("cfg_we", 128'(CFG_WE), 128'(we_e));
            chk("cfg_d", 128'(CFG_D), 128'(d_e));
            chk("busy", 128'(BUSY), 128'(m_pos >= 0));
            chk("load_ready", 128'(ld.LOAD_READY), 128'(m_pos == -1));
            chk("cfg_done", 128'(CFG_DONE), 128'(m_done));
            chk("layer_cnt", 128'(LAYER_CNT), 128'(m_layer));
        end
    end

    int           cap_n = 0;
    logic [127:0] cap = '0;
    logic [127:0] last_frame = '0;
    int           frames = 0;
    int           done_cnt = 0;

    initial forever begin
        @(negedge CLK or posedge RST);
        if (RST) begin
            cap_n = 0;
        end else begin
            if (CFG_DONE === 1'b1) done_cnt++;
            if (CFG_WE === 1'b1) begin
                cap[cap_n] = CFG_D;
                cap_n++;
                if (cap_n == 128) begin
                    chk("frame", cap, m_frame);
                    last_frame = cap;
                    frames++;
                    cap_n = 0;
                end
            end
        end
    end

    task automatic set_rec(input bit auto_d, input logic [4:0] hw, input logic [4:0] t,
                           input logic [4:0] d1, input logic [8:0] d2, input logic [79:0] vth,
                           input logic [15:0] noff, input logic [3:0] tpd, input logic [3:0] modes);
        ld.AUTO_DELAY   = auto_d;
        ld.LD_HW        = hw;
        ld.LD_T         = t;
        ld.LD_D1        = d1;
        ld.LD_D2        = d2;
        ld.LD_VTH       = vth;
        ld.LD_NOFF      = noff;
        ld.LD_TPD       = tpd;
        ld.LD_PD_EN_MEM = modes[0];
        ld.LD_PD_EN_CIM = modes[1];
        ld.LD_BP        = modes[2];
        ld.LD_SWP       = modes[3];
    endtask

    task automatic rand_fields();
        set_rec(1'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 9'($urandom),
                80'({$urandom(), $urandom(), $urandom()}), 16'($urandom), 4'($urandom),
                4'($urandom));
    endtask

    task automatic wait_accept();
        int start;
        int n;
        start = acc_cnt;
        n = 0;
        while (acc_cnt == start && n < 400) begin
            @(posedge CLK);
            #1;
            n++;
        end
        chk("accept_timeout", 128'(acc_cnt != start), 128'(1));
    endtask

    task automatic wait_idle(input bit toggle);
        int n;
        n = 0;
        while (m_pos != -1 && n < 400) begin
            if (toggle) rand_fields();
            @(posedge CLK);
            #1;
            n++;
        end
        chk("idle_timeout", 128'(m_pos == -1), 128'(1));
    endtask

    task automatic send(input bit toggle);
        ld.LOAD_VALID = 1'b1;
        wait_accept();
        ld.LOAD_VALID = 1'b0;
        wait_idle(toggle);
    endtask

    int d0;
    int f0;
    logic [79:0] vth_v;

    initial begin
        ld.LOAD_VALID = 1'b0;
        set_rec(1'b0, 5'd0, 5'd0, 5'd0, 9'd0, 80'd0, 16'd0, 4'd0, 4'd0);
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_cfg_we", 128'(CFG_WE), 128'(0));
        chk("rst_cfg_d", 128'(CFG_D), 128'(0));
        chk("rst_busy", 128'(BUSY), 128'(0));
        chk("rst_cfg_done", 128'(CFG_DONE), 128'(0));
        chk("rst_layer_cnt", 128'(LAYER_CNT), 128'(0));
        chk("rst_load_ready", 128'(ld.LOAD_READY), 128'(1));
        RST = 1'b0;
        @(posedge CLK);
        #1;

        vth_v = {16{5'd9}};
        set_rec(1'b1, 5'd15, 5'd7, 5'd0, 9'd0, vth_v, 16'd0, 4'd10, 4'b0011);
        send(1'b0);
        chk("t1_frames", 128'(frames), 128'(1));
        chk("t1_hw", 128'(last_frame[4:0]), 128'(15));
        chk("t1_t", 128'(last_frame[9:5]), 128'(7));
        chk("t1_d1", 128'(last_frame[14:10]), 128'(7));
        chk("t1_d2", 128'(last_frame[23:15]), 128'(103));
        chk("t1_vth", 128'(last_frame[103:24]), 128'(vth_v));
        chk("t1_noff", 128'(last_frame[119:104]), 128'(0));
        chk("t1_tpd", 128'(last_frame[123:120]), 128'(10));
        chk("t1_modes", 128'(last_frame[127:124]), 128'(4'b0011));

        set_rec(1'b1, 5'd3, 5'd7, 5'd0, 9'd0, 80'd0, 16'd0, 4'd0, 4'd0);
        send(1'b0);
        chk("auto_hw3_d2", 128'(last_frame[23:15]), 128'(7));
        set_rec(1'b1, 5'd1, 5'd3, 5'd17, 9'd200, 80'd0, 16'd0, 4'd0, 4'd0);
        send(1'b0);
        chk("auto_hw1_d2", 128'(last_frame[23:15]), 128'(3));
        chk("auto_hw1_d1", 128'(last_frame[14:10]), 128'(3));
        set_rec(1'b0, 5'd31, 5'd31, 5'd4, 9'h1AA, 80'd0, 16'd0, 4'd0, 4'd0);
        send(1'b0);
        chk("manual_d2", 128'(last_frame[23:15]), 128'(9'h1AA));
        chk("manual_d1", 128'(last_frame[14:10]), 128'(4));

        vth_v = {5'd1, 70'd0, 5'd31};
        set_rec(1'b1, 5'd2, 5'd2, 5'd0, 9'd0, vth_v, 16'h8001, 4'd0, 4'b1100);
        send(1'b0);
        chk("noff_bit104", 128'(last_frame[104]), 128'(1));
        chk("noff_bit119", 128'(last_frame[119]), 128'(1));
        chk("vth_n0", 128'(last_frame[28:24]), 128'(5'b11111));
        chk("vth_n15", 128'(last_frame[103:99]), 128'(5'b00001));
        chk("done_after_5", 128'(done_cnt), 128'(1));
        chk("layer_after_5", 128'(LAYER_CNT), 128'(0));

        d0 = done_cnt;
        rand_fields();
        ld.LOAD_VALID = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wait_accept();
            if (i > 0) chk("b2b_spacing", 128'(acc_cyc - prev_acc_cyc), 128'(130));
            if (i == 4) ld.LOAD_VALID = 1'b0;
            rand_fields();
        end
        wait_idle(1'b0);
        chk("b2b_done_once", 128'(done_cnt), 128'(d0 + 1));
        chk("b2b_layer_zero", 128'(LAYER_CNT), 128'(0));
        rand_fields();
        send(1'b0);
        chk("sixth_layer_one", 128'(LAYER_CNT), 128'(1));

        rand_fields();
        ld.LOAD_VALID = 1'b1;
        wait_accept();
        ld.LOAD_VALID = 1'b0;
        repeat (60) @(posedge CLK);
        #3;
        RST = 1'b1;
        #1;
        chk("abort_cfg_we", 128'(CFG_WE), 128'(0));
        chk("abort_load_ready", 128'(ld.LOAD_READY), 128'(1));
        chk("abort_layer_cnt", 128'(LAYER_CNT), 128'(0));
        chk("abort_busy", 128'(BUSY), 128'(0));
        @(posedge CLK);
        #1;
        RST = 1'b0;

        d0 = done_cnt;
        for (int i = 0; i < 5; i++) begin
            f0 = frames;
            rand_fields();
            send(1'b1);
            chk("restart_full_frame", 128'(frames), 128'(f0 + 1));
            chk("restart_done", 128'(done_cnt), 128'(i < 4 ? d0 : d0 + 1));
        end

        for (int i = 0; i < 4; i++) begin
            rand_fields();
            repeat ($urandom_range(0, 3)) @(posedge CLK);
            #1;
            send(1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
